// File: rtl/mem_responder.sv
// Memory-side responder: valid/ready requests into a DEPTH x WIDTH array, ready pulse after LATENCY wait cycles.
// Optional MEM_STATS_EN adds 16-bit completed-write/read counters (wr_cnt_o, rd_cnt_o).
module mem_responder #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LATENCY    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic                  wr_rd_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic                  ready_o,
    output logic [WIDTH-1:0]      rdata_o
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]           wr_cnt_o,
    output logic [15:0]           rd_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT4 = LATENCY[3:0];

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic                    wr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [WIDTH-1:0]        wdata_q;
    logic                    ready_q;
    logic [WIDTH-1:0]        rdata_q;
    logic [WIDTH-1:0]        mem_q [DEPTH];
`ifdef MEM_STATS_EN
    logic [15:0]             wr_cnt_q;
    logic [15:0]             rd_cnt_q;
`endif

    logic                    go_resp_d;
    logic                    req_wr_d;
    logic [ADDR_WIDTH-1:0]   req_addr_d;
    logic [WIDTH-1:0]        req_wdata_d;

    // With zero latency the commit happens on the capture edge itself, so use the live inputs.
    always_comb begin
        go_resp_d   = 1'b0;
        req_wr_d    = wr_q;
        req_addr_d  = addr_q;
        req_wdata_d = wdata_q;
        if (state_q == IDLE) begin
            req_wr_d    = wr_rd_i;
            req_addr_d  = addr_i;
            req_wdata_d = wdata_i;
            go_resp_d   = valid_i && (LAT4 == 4'd0);
        end else if (state_q == WAIT) begin
            go_resp_d   = (cnt_q == 4'd1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef MEM_STATS_EN
            wr_cnt_q <= 16'd0;
            rd_cnt_q <= 16'd0;
`endif
        end else begin
            ready_q <= go_resp_d;
            if (go_resp_d) begin
                if (req_wr_d) begin
                    mem_q[req_addr_d] <= req_wdata_d;
`ifdef MEM_STATS_EN
                    wr_cnt_q <= wr_cnt_q + 16'd1;
`endif
                end else begin
                    rdata_q <= mem_q[req_addr_d];
`ifdef MEM_STATS_EN
                    rd_cnt_q <= rd_cnt_q + 16'd1;
`endif
                end
            end

            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        wr_q    <= wr_rd_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        cnt_q   <= LAT4;
                        state_q <= (LAT4 == 4'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    // Mandatory bubble: a request presented now is taken on the next IDLE edge.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign rdata_o = rdata_q;
`ifdef MEM_STATS_EN
    assign wr_cnt_o = wr_cnt_q;
    assign rd_cnt_o = rd_cnt_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: instance 0 uses LATENCY=2, instance 1 uses LATENCY=0.
// Stats counters (MEM_STATS_EN) are checked only when the macro is defined.
module tb_mem_responder;

    logic        clk;
    logic        rst;
    logic        valid [2];
    logic        wrRd  [2];
    logic [5:0]  addr  [2];
    logic [15:0] wdata [2];
    logic        ready [2];
    logic [15:0] rdata [2];
`ifdef MEM_STATS_EN
    logic [15:0] wrCnt [2];
    logic [15:0] rdCnt [2];
`endif

    int checks   = 0;
    int failures = 0;

    logic [15:0] model  [2][64];
    logic [15:0] lastRd [2];
    int          wrExp  [2];
    int          rdExp  [2];

    mem_responder #(.WIDTH(16), .DEPTH(64), .LATENCY(2)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid[0]), .wr_rd_i(wrRd[0]),
        .addr_i(addr[0]), .wdata_i(wdata[0]), .ready_o(ready[0]), .rdata_o(rdata[0])
`ifdef MEM_STATS_EN
        , .wr_cnt_o(wrCnt[0]), .rd_cnt_o(rdCnt[0])
`endif
    );

    mem_responder #(.WIDTH(16), .DEPTH(64), .LATENCY(0)) dutZero (
        .clk_i(clk), .rst_i(rst), .valid_i(valid[1]), .wr_rd_i(wrRd[1]),
        .addr_i(addr[1]), .wdata_i(wdata[1]), .ready_o(ready[1]), .rdata_o(rdata[1])
`ifdef MEM_STATS_EN
        , .wr_cnt_o(wrCnt[1]), .rd_cnt_o(rdCnt[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int latOf(input int s);
        return (s == 0) ? 2 : 0;
    endfunction

    function automatic void clearModel();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 64; i++) model[s][i] = 16'h0000;
            lastRd[s] = 16'h0000;
            wrExp[s]  = 0;
            rdExp[s]  = 0;
        end
    endfunction

    // One complete transaction; optionally scrambles the inputs right after capture.
    task automatic applyStimulus(input int s, input bit wr, input logic [5:0] a,
                                 input logic [15:0] d, input bit midChange);
        int n;
        bit seen;
        @(negedge clk);
        valid[s] = 1'b1; wrRd[s] = wr; addr[s] = a; wdata[s] = d;
        @(posedge clk);
        #1;
        valid[s] = 1'b0;
        if (midChange) begin
            addr[s] = a + 6'd1; wdata[s] = ~d; wrRd[s] = ~wr;
        end
        if (wr) begin
            model[s][a] = d;
            wrExp[s]++;
        end else begin
            lastRd[s] = model[s][a];
            rdExp[s]++;
        end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (ready[s] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || n != latOf(s) + 1) begin
            failures++;
            $display("[TB] FAIL latency inst=%0d got=%0d cycles want=%0d", s, seen ? n : -1, latOf(s) + 1);
        end
        checks++;
        if (rdata[s] !== lastRd[s]) begin
            failures++;
            $display("[TB] FAIL rdata inst=%0d wr=%0d addr=%0d got=%h want=%h", s, wr, a, rdata[s], lastRd[s]);
        end
        @(negedge clk);
        checks++;
        if (ready[s] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ready_width inst=%0d got=%b want=0", s, ready[s]);
        end
    endtask

    task automatic checkOutput();
`ifdef MEM_STATS_EN
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (wrCnt[s] !== 16'(wrExp[s]) || rdCnt[s] !== 16'(rdExp[s])) begin
                failures++;
                $display("[TB] FAIL stats inst=%0d got wr=%0d rd=%0d want wr=%0d rd=%0d",
                         s, wrCnt[s], rdCnt[s], wrExp[s], rdExp[s]);
            end
        end
`endif
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (ready[s] !== 1'b0 || rdata[s] !== 16'h0000) begin
                    failures++;
                    $display("[TB] FAIL reset_state inst=%0d got ready=%b rdata=%h want ready=0 rdata=0000",
                             s, ready[s], rdata[s]);
                end
            end
        end
        rst = 1'b0;
        clearModel();
    endtask

    task automatic test_reset();
        doReset();
        checkOutput();
        applyStimulus(0, 1'b0, 6'd0, 16'h0, 1'b0);
        applyStimulus(0, 1'b0, 6'd63, 16'h0, 1'b0);
        applyStimulus(1, 1'b0, 6'd63, 16'h0, 1'b0);
    endtask

    task automatic test_write_read();
        applyStimulus(0, 1'b1, 6'd5, 16'hA5A5, 1'b0);
        applyStimulus(0, 1'b0, 6'd5, 16'h0, 1'b0);
        applyStimulus(0, 1'b1, 6'd63, 16'h5A5A, 1'b0);
        applyStimulus(0, 1'b0, 6'd63, 16'h0, 1'b0);
        checkOutput();
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        valid[0] = 1'b1; wrRd[0] = 1'b1; addr[0] = 6'd10; wdata[0] = 16'h1234;
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (ready[0] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL abort_ready got=%b want=0", ready[0]);
            end
        end
        rst = 1'b0;
        clearModel();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (ready[0] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL abort_after got=%b want=0", ready[0]);
            end
        end
        applyStimulus(0, 1'b0, 6'd10, 16'h0, 1'b0);
        checkOutput();
    endtask

    task automatic test_back_to_back();
        int n;
        int gap;
        bit seen;
        @(negedge clk);
        valid[0] = 1'b1; wrRd[0] = 1'b1; addr[0] = 6'd7; wdata[0] = 16'hBEEF;
        @(posedge clk);
        #1;
        wrRd[0] = 1'b0; wdata[0] = 16'h0000;
        model[0][7] = 16'hBEEF; wrExp[0]++;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk); n++;
            if (ready[0] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || n != 3) begin
            failures++;
            $display("[TB] FAIL b2b_first got=%0d want=3", seen ? n : -1);
        end
        @(negedge clk);
        @(negedge clk);
        valid[0] = 1'b0;
        lastRd[0] = model[0][7]; rdExp[0]++;
        gap = 2; seen = 1'b0;
        while (!seen && gap < 20) begin
            @(negedge clk); gap++;
            if (ready[0] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || gap != 4) begin
            failures++;
            $display("[TB] FAIL b2b_gap got=%0d want=4", seen ? gap : -1);
        end
        checks++;
        if (rdata[0] !== 16'hBEEF) begin
            failures++;
            $display("[TB] FAIL b2b_rdata got=%h want=beef", rdata[0]);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (ready[0] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL b2b_extra got=%b want=0", ready[0]);
            end
        end
        checkOutput();
    endtask

    task automatic test_mid_change();
        applyStimulus(0, 1'b1, 6'd3, 16'h1111, 1'b1);
        applyStimulus(0, 1'b0, 6'd3, 16'h0, 1'b0);
        applyStimulus(0, 1'b0, 6'd4, 16'h0, 1'b0);
    endtask

    task automatic test_zero_latency();
        doReset();
        applyStimulus(1, 1'b1, 6'd1, 16'h0101, 1'b0);
        applyStimulus(1, 1'b1, 6'd2, 16'h0202, 1'b1);
        applyStimulus(1, 1'b1, 6'd63, 16'hFFFF, 1'b0);
        applyStimulus(1, 1'b0, 6'd2, 16'h0, 1'b0);
        applyStimulus(1, 1'b0, 6'd63, 16'h0, 1'b0);
        checkOutput();
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int s;
            int pick;
            logic [5:0] a;
            s    = int'($urandom_range(0, 1));
            pick = int'($urandom_range(0, 3));
            a    = (pick == 0) ? 6'd0 : (pick == 1) ? 6'd63 : 6'($urandom_range(0, 63));
            applyStimulus(s, 1'($urandom_range(0, 1)), a, 16'($urandom), 1'($urandom_range(0, 1)));
        end
        checkOutput();
    endtask

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            valid[s] = 1'b0; wrRd[s] = 1'b0; addr[s] = 6'd0; wdata[s] = 16'h0;
        end
        clearModel();
        test_reset();
        test_write_read();
        test_reset_abort();
        test_back_to_back();
        test_mid_change();
        test_zero_latency();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
